// File: rtl/disc_flipper.sv
// Flip walker: from a newly placed disc, steps along one direction through board memory
// and recolours opponent discs until it meets the player's own disc, an empty cell or the edge.
module disc_flipper #(
    parameter int DIM_LOG2 = 3,
    parameter int ADDR_W   = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] s_addr_in,
    input  logic [2:0]        dir_in,
    input  logic              player,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_rdata,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        flip_count
);

    localparam int D = DIM_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One step from (row,col) in direction dir; MSB flags a step off the board.
    function automatic logic [2*D:0] f_step(
        input logic [D-1:0] row,
        input logic [D-1:0] col,
        input logic [2:0]   dir
    );
        logic         off;
        logic [D-1:0] nr;
        logic [D-1:0] nc;
        off = 1'b0;
        nr  = row;
        nc  = col;
        case (dir)
            3'd0, 3'd1, 3'd7: begin
                if (row == {D{1'b0}}) off = 1'b1;
                else                  nr  = row - {{(D-1){1'b0}}, 1'b1};
            end
            3'd3, 3'd4, 3'd5: begin
                if (row == {D{1'b1}}) off = 1'b1;
                else                  nr  = row + {{(D-1){1'b0}}, 1'b1};
            end
            default: nr = row;
        endcase
        case (dir)
            3'd1, 3'd2, 3'd3: begin
                if (col == {D{1'b1}}) off = 1'b1;
                else                  nc  = col + {{(D-1){1'b0}}, 1'b1};
            end
            3'd5, 3'd6, 3'd7: begin
                if (col == {D{1'b0}}) off = 1'b1;
                else                  nc  = col - {{(D-1){1'b0}}, 1'b1};
            end
            default: nc = col;
        endcase
        return {off, nr, nc};
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [D-1:0]      r_row;
    logic [D-1:0]      r_col;
    logic [2:0]        r_dir;
    logic [1:0]        r_colour;
    logic              r_offb;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_flip_count;
    logic              r_err;

    logic [2*D:0]      w_start_step;
    logic [2*D:0]      w_next_step;
    logic              w_org_valid;
    logic              w_is_opp;
    logic              w_is_own;

    // An origin with address bits above the row/col field is not a board cell.
    assign w_org_valid  = ((s_addr_in >> (2 * D)) == '0);
    assign w_start_step = f_step(s_addr_in[2*D-1:D], s_addr_in[D-1:0], dir_in);
    assign w_next_step  = f_step(r_row, r_col, r_dir);
    assign w_is_opp     = (mem_rdata == ~r_colour);
    assign w_is_own     = (mem_rdata == r_colour);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic; the off-board origin case passes through READ without a memory access.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_READ;
                else       w_next_state = S_IDLE;
            end
            S_READ: begin
                if (r_offb) w_next_state = S_DONE;
                else        w_next_state = S_CHECK;
            end
            S_CHECK: begin
                if (w_is_opp && !w_next_step[2*D]) w_next_state = S_READ;
                else                               w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Walk position, latched pass parameters and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row        <= {D{1'b0}};
            r_col        <= {D{1'b0}};
            r_dir        <= 3'd0;
            r_colour     <= 2'b00;
            r_offb       <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_flip_count <= 3'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dir        <= dir_in;
                        r_colour     <= player ? 2'b10 : 2'b01;
                        r_flip_count <= 3'd0;
                        r_err        <= 1'b0;
                        r_offb       <= w_start_step[2*D] | ~w_org_valid;
                        r_row        <= w_start_step[2*D-1:D];
                        r_col        <= w_start_step[D-1:0];
                        if (!w_start_step[2*D] && w_org_valid)
                            r_mem_addr <= ADDR_W'(w_start_step[2*D-1:0]);
                    end
                end
                S_READ: begin
                    if (r_offb) r_err <= 1'b1;
                end
                S_CHECK: begin
                    if (w_is_opp) begin
                        r_flip_count <= r_flip_count + 3'd1;
                        if (w_next_step[2*D]) begin
                            r_err <= 1'b1;
                        end else begin
                            r_row      <= w_next_step[2*D-1:D];
                            r_col      <= w_next_step[D-1:0];
                            r_mem_addr <= ADDR_W'(w_next_step[2*D-1:0]);
                        end
                    end else if (!w_is_own) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_err <= r_err;
            endcase
        end
    end

    // The write must land in the same cycle the read data arrives, so mem_we is decoded directly.
    assign mem_we     = (r_state == S_CHECK) && w_is_opp && !reset;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_colour;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign flip_count = r_flip_count;

endmodule
